// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-index
// width, the hazard-controller state encodings and the stall-depth helper.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_e;

  // A branch resolved in ID that depends on a load needs the value
  // two cycles later; a load-use or ALU-to-branch dependency needs one.
  function automatic logic [1:0] stalls_needed(input logic branch,
                                               input logic hz,
                                               input logic load);
    if (branch && hz && load) return 2'd2;
    if (hz && (load || branch)) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/hazard_mem_watchdog.sv
// Counts cycles spent waiting on data memory and raises a sticky timeout
// once the wait has lasted MEM_TIMEOUT cycles.
module hazard_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic count_en_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  // The counter saturates at the limit; the timeout flag only ever sets.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (clear_i) begin
      wait_cnt_d = 8'd0;
    end else if (start_i) begin
      wait_cnt_d = 8'd1;
    end else if (count_en_i) begin
      if (wait_cnt_q >= LIMIT) begin
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Optional HAZARD_STATS_EN macro adds stall_cycles / flush_count counters.
module hazard_detection_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             ID_branch,
  input  logic             ID_branch_taken,
  input  logic             ID_jump,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_mem_read,
  input  logic             EX_MEM_mem_read,
  input  logic             EX_MEM_mem_write,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             ID_EX_bubble,
  output logic             MEM_WB_bubble,
  output logic             IF_ID_flush,
  output logic             mem_timeout,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  state_e     state_q, state_d, eff_state, saved_q, saved_d;
  logic [1:0] stall_cnt_q, stall_cnt_d, need;
  logic       mem_busy, hz_rs, hz_rt, hz, redirect;
  logic       wd_start, wd_count, wd_clear, wd_timeout;
  logic       pc_wr, ifid_wr, idex_wr, exmem_wr, idex_bub, memwb_bub, flush;

  assign mem_busy  = (EX_MEM_mem_read | EX_MEM_mem_write) & ~dmem_ready;
  assign hz_rs     = (IF_ID_rs != REG_ZERO) && (IF_ID_rs == ID_EX_rd);
  assign hz_rt     = IF_ID_uses_rt && (IF_ID_rt != REG_ZERO) && (IF_ID_rt == ID_EX_rd);
  assign hz        = ID_EX_reg_write & (hz_rs | hz_rt);
  assign need      = stalls_needed(ID_branch, hz, ID_EX_mem_read);
  assign redirect  = ID_jump | (ID_branch & ID_branch_taken);
  // The unused encoding behaves exactly like RUN for one cycle.
  assign eff_state = (state_q inside {RUN, DSTALL, MWAIT}) ? state_q : RUN;

  always_comb begin
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    idex_wr     = 1'b1;
    exmem_wr    = 1'b1;
    idex_bub    = 1'b0;
    memwb_bub   = 1'b0;
    flush       = 1'b0;
    state_d     = eff_state;
    saved_d     = saved_q;
    stall_cnt_d = stall_cnt_q;
    wd_start    = 1'b0;
    wd_count    = 1'b0;
    wd_clear    = 1'b0;
    if (mem_busy) begin
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_wr   = 1'b0;
      exmem_wr  = 1'b0;
      memwb_bub = 1'b1;
      if (eff_state == MWAIT) begin
        wd_count = 1'b1;
      end else begin
        saved_d  = eff_state;
        wd_start = 1'b1;
        state_d  = MWAIT;
      end
    end else begin
      case (eff_state)
        MWAIT: begin
          state_d  = saved_q;
          wd_clear = 1'b1;
        end
        DSTALL: begin
          pc_wr    = 1'b0;
          ifid_wr  = 1'b0;
          idex_bub = 1'b1;
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_d = 2'd0;
            state_d     = RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
        default: begin
          if (need != 2'd0) begin
            pc_wr    = 1'b0;
            ifid_wr  = 1'b0;
            idex_bub = 1'b1;
            if (need == 2'd2) begin
              stall_cnt_d = 2'd1;
              state_d     = DSTALL;
            end
          end else if (redirect) begin
            flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (wd_start),
    .count_en_i (wd_count),
    .clear_i    (wd_clear),
    .timeout_o  (wd_timeout)
  );

  // While reset is held the pipeline free-runs with no bubbles or flushes.
  assign pc_write      = rst_n ? pc_wr     : 1'b1;
  assign IF_ID_write   = rst_n ? ifid_wr   : 1'b1;
  assign ID_EX_write   = rst_n ? idex_wr   : 1'b1;
  assign EX_MEM_write  = rst_n ? exmem_wr  : 1'b1;
  assign ID_EX_bubble  = rst_n & idex_bub;
  assign MEM_WB_bubble = rst_n & memwb_bub;
  assign IF_ID_flush   = rst_n & flush;
  assign mem_timeout   = rst_n & wd_timeout;
  assign state         = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!pc_wr && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush && (flush_count_q != 32'hFFFF_FFFF))   flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit (MEM_TIMEOUT=4).
// Exercises HAZARD_STATS_EN counters when that macro is defined.
module tb_hazard_detection_unit;

  localparam logic [6:0] CTL_RUN    = 7'b1111_000;
  localparam logic [6:0] CTL_STALL  = 7'b0011_100;
  localparam logic [6:0] CTL_FREEZE = 7'b0000_010;
  localparam logic [6:0] CTL_FLUSH  = 7'b1111_001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rd;
  logic       IF_ID_uses_rt, ID_branch, ID_branch_taken, ID_jump;
  logic       ID_EX_reg_write, ID_EX_mem_read, EX_MEM_mem_read, EX_MEM_mem_write, dmem_ready;
  logic       pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic       ID_EX_bubble, MEM_WB_bubble, IF_ID_flush, mem_timeout;
  logic [1:0] state;
  logic [6:0] ctl;
  int         total = 0;
  int         bad = 0;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  assign ctl = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                ID_EX_bubble, MEM_WB_bubble, IF_ID_flush};

  always #5 clk = ~clk;

  hazard_detection_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
    .ID_branch(ID_branch), .ID_branch_taken(ID_branch_taken), .ID_jump(ID_jump),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .ID_EX_bubble(ID_EX_bubble), .MEM_WB_bubble(MEM_WB_bubble),
    .IF_ID_flush(IF_ID_flush), .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b0;
    ID_branch = 1'b0; ID_branch_taken = 1'b0; ID_jump = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_reg_write = 1'b0; ID_EX_mem_read = 1'b0;
    EX_MEM_mem_read = 1'b0; EX_MEM_mem_write = 1'b0; dmem_ready = 1'b1;
  endtask

  // lw $3 in EX feeding a beq on $3 in ID.
  task automatic load_branch();
    idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd3;
    IF_ID_rs = 5'd3; IF_ID_rt = 5'd7; IF_ID_uses_rt = 1'b1; ID_branch = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd2; IF_ID_rs = 5'd2;
    EX_MEM_mem_read = 1'b1; dmem_ready = 1'b0;
    #3;
    total++;
    if (ctl !== CTL_RUN) begin bad++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_RUN); end
    total++;
    if (state !== 2'd0 || mem_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_state got state=%0d tmo=%b want 0/0", state, mem_timeout);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN || state !== 2'd0) begin
      bad++; $display("FAIL post_reset got ctl=%b state=%0d want %b/0", ctl, state, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd2; IF_ID_rs = 5'd2;
    @(negedge clk);
    total++;
    if (ctl !== CTL_STALL || state !== 2'd0) begin
      bad++; $display("FAIL loaduse_stall got ctl=%b state=%0d want %b/0", ctl, state, CTL_STALL);
    end
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN || state !== 2'd0) begin
      bad++; $display("FAIL loaduse_release got ctl=%b state=%0d want %b/0", ctl, state, CTL_RUN);
    end
    tick();
    idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd9;
    IF_ID_rs = 5'd1; IF_ID_rt = 5'd9; IF_ID_uses_rt = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN) begin bad++; $display("FAIL loaduse_rt_unused got %b want %b", ctl, CTL_RUN); end
    IF_ID_uses_rt = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_STALL) begin bad++; $display("FAIL loaduse_rt_used got %b want %b", ctl, CTL_STALL); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_branch_load();
    int lowpc = 0;
    logic [1:0] exp_st [3] = '{2'd0, 2'd1, 2'd0};
    logic [6:0] exp_ctl [3] = '{CTL_STALL, CTL_STALL, CTL_RUN};
    load_branch();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) idle();
      @(negedge clk);
      if (!pc_write) lowpc++;
      total++;
      if (ctl !== exp_ctl[c] || state !== exp_st[c]) begin
        bad++; $display("FAIL branch_load c%0d got ctl=%b state=%0d want %b/%0d",
                        c, ctl, state, exp_ctl[c], exp_st[c]);
      end
      tick();
    end
    total++;
    if (lowpc != 2) begin bad++; $display("FAIL branch_load_len got %0d want 2", lowpc); end
  endtask

  task automatic test_flush();
    idle();
    ID_EX_rd = 5'd0; ID_EX_reg_write = 1'b1; ID_EX_mem_read = 1'b1;
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN) begin bad++; $display("FAIL zero_reg got %b want %b", ctl, CTL_RUN); end
    tick();
    idle();
    ID_EX_rd = 5'd5; ID_EX_reg_write = 1'b1;
    IF_ID_rs = 5'd1; IF_ID_rt = 5'd2; IF_ID_uses_rt = 1'b1;
    ID_branch = 1'b1; ID_branch_taken = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== CTL_FLUSH) begin bad++; $display("FAIL taken_flush got %b want %b", ctl, CTL_FLUSH); end
    tick();
    ID_branch = 1'b0; ID_branch_taken = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN) begin bad++; $display("FAIL flush_one_cycle got %b want %b", ctl, CTL_RUN); end
    ID_branch = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_RUN) begin bad++; $display("FAIL not_taken got %b want %b", ctl, CTL_RUN); end
    ID_branch = 1'b0; ID_jump = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_FLUSH) begin bad++; $display("FAIL jump_flush got %b want %b", ctl, CTL_FLUSH); end
    ID_jump = 1'b0; ID_branch = 1'b1; ID_branch_taken = 1'b1; IF_ID_rt = 5'd5;
    #1;
    total++;
    if (ctl !== CTL_STALL || state !== 2'd0) begin
      bad++; $display("FAIL alu_branch_no_flush got ctl=%b state=%0d want %b/0", ctl, state, CTL_STALL);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_mem_wait_dstall();
    logic [1:0] exp_st [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    logic [6:0] exp_ctl [6] = '{CTL_FREEZE, CTL_FREEZE, CTL_FREEZE, CTL_RUN, CTL_STALL, CTL_RUN};
    load_branch();
    tick();
    EX_MEM_mem_write = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) dmem_ready = 1'b1;
      if (c == 4) EX_MEM_mem_write = 1'b0;
      if (c == 5) idle();
      @(negedge clk);
      total++;
      if (ctl !== exp_ctl[c] || state !== exp_st[c]) begin
        bad++; $display("FAIL memwait c%0d got ctl=%b state=%0d want %b/%0d",
                        c, ctl, state, exp_ctl[c], exp_st[c]);
      end
      tick();
    end
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL memwait_no_timeout got %b want 0", mem_timeout); end
  endtask

  task automatic test_timeout();
    idle();
    EX_MEM_mem_read = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== CTL_FREEZE || mem_timeout !== (c >= 5)) begin
        bad++; $display("FAIL timeout c%0d got ctl=%b tmo=%b want %b/%b",
                        c, ctl, mem_timeout, CTL_FREEZE, (c >= 5));
      end
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== CTL_RUN || state !== 2'd2 || mem_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_done got ctl=%b state=%0d tmo=%b want %b/2/1", ctl, state, mem_timeout, CTL_RUN);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    total++;
    if (mem_timeout !== 1'b1 || state !== 2'd0) begin
      bad++; $display("FAIL timeout_sticky got tmo=%b state=%0d want 1/0", mem_timeout, state);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got %b want 0", mem_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_dstall();
    load_branch();
    tick();
    #2;
    total++;
    if (state !== 2'd1) begin bad++; $display("FAIL midrst_setup got state=%0d want 1", state); end
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 2'd0 || ctl !== CTL_RUN) begin
      bad++; $display("FAIL midrst_async got state=%0d ctl=%b want 0/%b", state, ctl, CTL_RUN);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    load_branch();
    tick();
    tick();
    idle();
    ID_branch = 1'b1; ID_branch_taken = 1'b1;
    tick();
    idle();
    tick();
    @(negedge clk);
    total++;
    if (stall_cycles !== 32'd2 || flush_count !== 32'd1) begin
      bad++; $display("FAIL stats got stall=%0d flush=%0d want 2/1", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_load();
    test_flush();
    test_mem_wait_dstall();
    test_timeout();
    test_reset_mid_dstall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; the forwarding unit resolves what bypass can fix, this block handles what it cannot.
- Detects load-use and ID-stage branch data hazards, multi-cycle data-memory waits, and taken branches/jumps.
- Drives pipeline-register write enables, bubble inserts and IF/ID flush.
- Registered FSM with stall counter and memory-wait watchdog.

Parameters:
- MEM_TIMEOUT, 255: max cycles in memory wait before mem_timeout is raised (1..255; 8-bit counter).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_rs  in  5  rs of instruction in ID
- IF_ID_rt  in  5  rt of instruction in ID
- IF_ID_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- ID_branch  in  1  ID instruction is a conditional branch, resolved in ID
- ID_branch_taken  in  1  branch comparison true; meaningful only with ID_branch
- ID_jump  in  1  ID instruction is j/jal/jr
- ID_EX_rd  in  5  destination register of EX instruction (post RegDst mux)
- ID_EX_reg_write  in  1  EX instruction writes a register
- ID_EX_mem_read  in  1  EX instruction is a load
- EX_MEM_mem_read  in  1  MEM-stage load
- EX_MEM_mem_write  in  1  MEM-stage store
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_write  out  1  PC load enable
- IF_ID_write  out  1  IF/ID load enable
- ID_EX_write  out  1  ID/EX load enable
- EX_MEM_write  out  1  EX/MEM load enable
- ID_EX_bubble  out  1  zero control fields entering ID/EX
- MEM_WB_bubble  out  1  zero control fields entering MEM/WB
- IF_ID_flush  out  1  replace IF/ID with nop
- mem_timeout  out  1  sticky watchdog error
- state  out  2  FSM state (debug)

Behaviour:
- States: RUN=0, DSTALL=1, MWAIT=2. Reset: state RUN, stall_cnt 0, wait_cnt 0, saved_state RUN, mem_timeout 0.
- Outputs are combinational from state and inputs. While rst_n low: all enables 1; bubbles, flush and mem_timeout 0.
- Registers are written only when rst_n is high.
- mem_busy = (EX_MEM_mem_read | EX_MEM_mem_write) & ~dmem_ready.
- hz_rs = IF_ID_rs != 0 && IF_ID_rs == ID_EX_rd. hz_rt is the same but also requires IF_ID_uses_rt. hz = ID_EX_reg_write & (hz_rs | hz_rt).
- Required stall count N:
  - N=2: ID_branch & hz & ID_EX_mem_read.
  - N=1: otherwise ID_EX_mem_read & hz, or ID_branch & hz.
  - N=0: otherwise.
- Priority: mem_busy > data stall > flush.
- Freeze, while mem_busy in any state:
  - pc_write, IF_ID_write, ID_EX_write and EX_MEM_write = 0; MEM_WB_bubble = 1.
  - Entering from RUN or DSTALL: saved_state = current state, stall_cnt held, wait_cnt = 1, next state MWAIT.
  - In MWAIT: wait_cnt increments, saturating at MEM_TIMEOUT. When wait_cnt == MEM_TIMEOUT while still busy, mem_timeout is set and stays set until reset. Freeze continues.
- MWAIT with dmem_ready=1 (completion cycle):
  - All enables 1, no bubble; the pipeline advances.
  - Next state = saved_state; wait_cnt cleared.
  - No new hazard evaluation in this cycle.
- RUN, not mem_busy:
  - N>0: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, other enables 1.
  - N=2: stall_cnt=1, next state DSTALL. N=1: stay RUN; the bubble removes the hazard.
  - N=0 and (ID_jump | ID_branch & ID_branch_taken): IF_ID_flush=1, all enables 1. This is a 1-cycle penalty.
  - Flush is never asserted in the same cycle as a data stall.
- DSTALL, not mem_busy: same stall outputs as N>0. stall_cnt decrements; on reaching 0, next state RUN. Hazard inputs are ignored in this state.
- Timing: total stall for N=2 is exactly 2 cycles; load-use stall is exactly 1 cycle.
- Unused encoding 3 returns to RUN on the next cycle with RUN outputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - stall_cycles increments on every cycle where pc_write=0.
  - flush_count increments on every IF_ID_flush cycle.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package/header (mips_pkg): state encodings RUN/DSTALL/MWAIT, REG_ZERO=5'd0, and register-index width 5.
- One natural sub-module: hazard_mem_watchdog, containing the wait counter, saturation logic and sticky mem_timeout, with inputs for count enable, clear and timeout.

Test Plan:
- lw $2 in EX (ID_EX_mem_read=1, ID_EX_rd=2), add using rs=2 in ID -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle with a clean EX has all enables 1.
- lw $3 in EX, beq rs=3 in ID -> state goes to DSTALL; pc_write=0 for exactly 2 consecutive cycles, then RUN.
- ID_EX_rd=0 with reg_write=1, rs=0 -> no stall; beq taken with no hazard -> IF_ID_flush=1 for 1 cycle, pc_write=1.
- sw in MEM, dmem_ready low for 3 cycles during DSTALL -> 3 cycles with all enables 0 and MEM_WB_bubble=1; then one advance cycle; return to DSTALL and complete the remaining stall cycle.
- MEM_TIMEOUT=4, dmem_ready held low -> mem_timeout rises when wait_cnt reaches 4 and stays 1 after dmem_ready; cleared only by rst_n low.
- rst_n asserted low mid-DSTALL -> state=0 and all enables 1 immediately, without waiting for a clock edge.
- With HAZARD_STATS_EN: one N=2 stall plus one flush -> stall_cycles=2, flush_count=1.
